// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, instruction codes and IR capture pattern.
// Optional IDCODE support is selected with `define JTAG_TAP_IDCODE_EN.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [2:0] {
        OP_EXTEST, OP_SAMPLE, OP_IDCODE, OP_MBIST, OP_DEBUG, OP_BYPASS
    } instr_e;

    localparam logic [3:0] INSTR_EXTEST         = 4'b0000;
    localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] INSTR_IDCODE         = 4'b0010;
    localparam logic [3:0] INSTR_MBIST          = 4'b1000;
    localparam logic [3:0] INSTR_DEBUG          = 4'b1001;

    localparam logic [1:0]  IR_CAPTURE_PATTERN = 2'b01;
    localparam logic [31:0] IDCODE_VAL_DEFAULT = 32'h1180_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered Moore strobes.
// Strobes are decoded from the next state so they line up with state_q.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    output logic tlr_next_o,
    output logic tlr_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o
);

    tap_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_i ? TLR    : RTI;
            RTI:     state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign tlr_next_o = rst_i | (state_d == TLR);

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q      <= TLR;
            tlr_o        <= 1'b1;
            capture_dr_o <= 1'b0;
            shift_dr_o   <= 1'b0;
            pause_dr_o   <= 1'b0;
            update_dr_o  <= 1'b0;
            capture_ir_o <= 1'b0;
            shift_ir_o   <= 1'b0;
            update_ir_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tlr_o        <= (state_d == TLR);
            capture_dr_o <= (state_d == CAP_DR);
            shift_dr_o   <= (state_d == SH_DR);
            pause_dr_o   <= (state_d == PA_DR);
            update_dr_o  <= (state_d == UPD_DR);
            capture_ir_o <= (state_d == CAP_IR);
            shift_ir_o   <= (state_d == SH_IR);
            update_ir_o  <= (state_d == UPD_IR);
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, BYPASS, optional IDCODE and TDO return mux.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = IDCODE_VAL_DEFAULT
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    output logic debug_select_o,
    input  logic bs_chain_tdo_i,
    input  logic mbist_tdo_i,
    input  logic debug_tdo_i
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] RESET_INSTR = IR_LEN'(INSTR_IDCODE);
`else
    localparam logic [IR_LEN-1:0] RESET_INSTR = '1;
`endif

    logic tlr_next, capture_ir, shift_ir, update_ir;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_active_q, ir_active_d;
    logic bypass_q, bypass_d;
    instr_e op;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .rst_i        (rst_i),
        .tms_i        (tms_i),
        .tlr_next_o   (tlr_next),
        .tlr_o        (test_logic_reset_o),
        .capture_dr_o (capture_dr_o),
        .shift_dr_o   (shift_dr_o),
        .pause_dr_o   (pause_dr_o),
        .update_dr_o  (update_dr_o),
        .capture_ir_o (capture_ir),
        .shift_ir_o   (shift_ir),
        .update_ir_o  (update_ir)
    );

    // Unlisted codes fall through to BYPASS.
    function automatic instr_e decode(input logic [IR_LEN-1:0] code);
        instr_e res;
        res = OP_BYPASS;
        if (code == IR_LEN'(INSTR_EXTEST))
            res = OP_EXTEST;
        if (code == IR_LEN'(INSTR_SAMPLE_PRELOAD))
            res = OP_SAMPLE;
        if (code == IR_LEN'(INSTR_MBIST))
            res = OP_MBIST;
        if (code == IR_LEN'(INSTR_DEBUG))
            res = OP_DEBUG;
`ifdef JTAG_TAP_IDCODE_EN
        if (code == IR_LEN'(INSTR_IDCODE))
            res = OP_IDCODE;
`endif
        return res;
    endfunction

    always_comb begin
        op = decode(ir_active_q);

        ir_shift_d = ir_shift_q;
        if (capture_ir)
            ir_shift_d = IR_LEN'(IR_CAPTURE_PATTERN);
        else if (shift_ir)
            ir_shift_d = {tdi_i, ir_shift_q[IR_LEN-1:1]};

        ir_active_d = ir_active_q;
        if (tlr_next)
            ir_active_d = RESET_INSTR;
        else if (update_ir)
            ir_active_d = ir_shift_q;

        bypass_d = bypass_q;
        if (capture_dr_o)
            bypass_d = 1'b0;
        else if (shift_dr_o && op == OP_BYPASS)
            bypass_d = tdi_i;
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            ir_shift_q  <= IR_LEN'(IR_CAPTURE_PATTERN);
            ir_active_q <= RESET_INSTR;
            bypass_q    <= 1'b0;
        end else begin
            ir_shift_q  <= ir_shift_d;
            ir_active_q <= ir_active_d;
            bypass_q    <= bypass_d;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_shift_q, idcode_shift_d;

    always_comb begin
        idcode_shift_d = idcode_shift_q;
        if (capture_dr_o)
            idcode_shift_d = IDCODE_VAL;
        else if (shift_dr_o)
            idcode_shift_d = {tdi_i, idcode_shift_q[31:1]};
    end

    always_ff @(posedge tck_i) begin
        if (rst_i)
            idcode_shift_q <= IDCODE_VAL;
        else
            idcode_shift_q <= idcode_shift_d;
    end
`endif

    always_comb begin
        tdo_o = 1'b0;
        if (shift_ir) begin
            tdo_o = ir_shift_q[0];
        end else if (shift_dr_o) begin
            case (op)
                OP_EXTEST, OP_SAMPLE: tdo_o = bs_chain_tdo_i;
                OP_MBIST:             tdo_o = mbist_tdo_i;
                OP_DEBUG:             tdo_o = debug_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
                OP_IDCODE:            tdo_o = idcode_shift_q[0];
`endif
                default:              tdo_o = bypass_q;
            endcase
        end
    end

    assign tdo_oe_o                = shift_dr_o | shift_ir;
    assign extest_select_o         = (op == OP_EXTEST);
    assign sample_preload_select_o = (op == OP_SAMPLE);
    assign mbist_select_o          = (op == OP_MBIST);
    assign debug_select_o          = (op == OP_DEBUG);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl against a TAP reference model.
// Honours JTAG_TAP_IDCODE_EN when the build defines it.
module tb_jtag_tap_ctrl;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4;
    localparam int EX1DR = 5, PADR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9;
    localparam int CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13;
    localparam int EX2IR = 14, UPDIR = 15;
    localparam int K_EXT = 0, K_SP = 1, K_ID = 2, K_MB = 3, K_DBG = 4;
    localparam int K_BYP = 5;
`ifdef JTAG_TAP_IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam logic [31:0] IDV = 32'h1180_0001;
    localparam int RESET_IR = ID_EN ? 2 : 15;

    int n0[16] = '{RTI, RTI, CAPDR, SHDR, SHDR, PADR, PADR, SHDR,
                   RTI, CAPIR, SHIR, SHIR, PAIR, PAIR, SHIR, RTI};
    int n1[16] = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UPDDR, EX2DR, UPDDR,
                   SELDR, TLR, EX1IR, EX1IR, UPDIR, EX2IR, UPDIR, SELDR};

    logic tck = 1'b0, rst_i = 1'b1, tms_i = 1'b0, tdi_i = 1'b0;
    logic bs = 1'b0, mb = 1'b0, dbg = 1'b0;
    logic tdo, oe, tlr, cdr, sdr, pdr, udr, se, ssp, smb, sdbg;

    int tests = 0, fails = 0;
    int st = TLR, m_ir = RESET_IR, m_irs = 1;
    bit m_byp = 1'b0;
    logic [31:0] m_idc = IDV;
    logic last_tdo, last_dbg;
    bit chk_en = 1'b0;

    always #5 tck = ~tck;

    jtag_tap_ctrl dut (
        .tck_i                   (tck),
        .rst_i                   (rst_i),
        .tms_i                   (tms_i),
        .tdi_i                   (tdi_i),
        .tdo_o                   (tdo),
        .tdo_oe_o                (oe),
        .test_logic_reset_o      (tlr),
        .capture_dr_o            (cdr),
        .shift_dr_o              (sdr),
        .pause_dr_o              (pdr),
        .update_dr_o             (udr),
        .extest_select_o         (se),
        .sample_preload_select_o (ssp),
        .mbist_select_o          (smb),
        .debug_select_o          (sdbg),
        .bs_chain_tdo_i          (bs),
        .mbist_tdo_i             (mb),
        .debug_tdo_i             (dbg)
    );

    function automatic int kind(input int ir);
        case (ir)
            0: return K_EXT;
            1: return K_SP;
            2: return ID_EN ? K_ID : K_BYP;
            8: return K_MB;
            9: return K_DBG;
            default: return K_BYP;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        int k;
        logic et;
        k = kind(m_ir);
        chk("tlr", tlr, st == TLR);
        chk("capture_dr", cdr, st == CAPDR);
        chk("shift_dr", sdr, st == SHDR);
        chk("pause_dr", pdr, st == PADR);
        chk("update_dr", udr, st == UPDDR);
        chk("tdo_oe", oe, st == SHDR || st == SHIR);
        chk("sel_extest", se, k == K_EXT);
        chk("sel_sample", ssp, k == K_SP);
        chk("sel_mbist", smb, k == K_MB);
        chk("sel_debug", sdbg, k == K_DBG);
        et = 1'b0;
        if (st == SHIR)
            et = m_irs[0];
        else if (st == SHDR) begin
            case (k)
                K_EXT, K_SP: et = bs;
                K_MB:        et = mb;
                K_DBG:       et = dbg;
                K_ID:        et = m_idc[0];
                default:     et = m_byp;
            endcase
        end
        chk("tdo", tdo, et);
    endtask

    task automatic tick(input bit t, input bit d);
        int s, ns;
        @(negedge tck);
        tms_i = t;
        tdi_i = d;
        bs = 1'($urandom);
        mb = 1'($urandom);
        dbg = 1'($urandom);
        #1;
        if (chk_en) check_outs();
        last_tdo = tdo;
        last_dbg = dbg;
        @(posedge tck);
        s = st;
        if (rst_i) begin
            st = TLR;
            m_ir = RESET_IR;
            m_byp = 1'b0;
        end else begin
            ns = t ? n1[s] : n0[s];
            if (s == CAPIR)
                m_irs = 1;
            else if (s == SHIR)
                m_irs = (m_irs >> 1) | (int'(d) << 3);
            if (s == CAPDR) begin
                m_byp = 1'b0;
                m_idc = IDV;
            end else if (s == SHDR) begin
                if (kind(m_ir) == K_BYP) m_byp = d;
                m_idc = {d, m_idc[31:1]};
            end
            if (ns == TLR)
                m_ir = RESET_IR;
            else if (s == UPDIR)
                m_ir = m_irs;
            st = ns;
        end
        #2;
    endtask

    task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, v[i]);
            o[i] = last_tdo;
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din,
                           output logic [31:0] dout,
                           output logic [31:0] dbgv);
        dout = '0;
        dbgv = '0;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i]);
            dout[i] = last_tdo;
            dbgv[i] = last_dbg;
        end
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        logic [3:0] iro;
        logic [31:0] dro, dbv;
        logic [3:0] v;

        rst_i = 1'b1;
        tick(0, 0);
        chk_en = 1'b1;
        rst_i = 1'b0;
        chk("rst_tlr", tlr, 1);
        chk("rst_sels", {se, ssp, smb, sdbg}, 0);
        tick(0, 0);

        dr_scan(32, 32'h0, dro, dbv);
        chk("idcode_stream", dro, ID_EN ? IDV : 32'h0);
        chk("first_dr_bit", dro[0], ID_EN);

        scan_ir(4'b0000, iro);
        chk("ir_capture_out", iro, 4'b0001);
        chk("extest_after_upd", se, 1);

        scan_ir(4'b1111, iro);
        dr_scan(4, 32'b1101, dro, dbv);
        chk("bypass_stream", dro[3:0], 4'b1010);

        scan_ir(4'b1001, iro);
        chk("debug_sel", sdbg, 1);
        dr_scan(16, $urandom, dro, dbv);
        chk("debug_route", dro[15:0], dbv[15:0]);

        scan_ir(4'b1000, iro);
        chk("mbist_sel", smb, 1);

        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        repeat (5) tick(1, 0);
        chk("tms5_tlr", tlr, 1);
        chk("tms5_sels", {se, ssp, smb, sdbg}, 0);

        tick(0, 0);
        scan_ir(4'b1001, iro);
        tick(1, 0);
        tick(0, 0);
        tick(0, 1);
        rst_i = 1'b1;
        tick(0, 1);
        rst_i = 1'b0;
        chk("midshift_rst_tlr", tlr, 1);
        chk("midshift_no_upd", udr, 0);
        chk("midshift_sel", sdbg, 0);
        tick(1, 0);
        chk("midshift_no_upd2", udr, 0);

        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 49) == 0);
            tick($urandom_range(0, 99) < 40, 1'($urandom));
        end
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            repeat (5) tick(1, 0);
            tick(0, 0);
            v = 4'($urandom);
            scan_ir(v, iro);
            chk("rnd_ir_capture", iro, 4'b0001);
            dr_scan($urandom_range(1, 32), $urandom, dro, dbv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller that drives the test-interface DR-control strobes and instruction selects.
- Contains the 16-state TAP FSM, the instruction register (IR), the BYPASS register, an optional IDCODE register and the TDO return mux.
- Sits between the chip JTAG pins and the test interface block, which consumes its strobes and selects.
- Everything is clocked on tck_i.

Parameters:
IR_LEN, 4, instruction register width (minimum 2)
IDCODE_VAL, 32'h1180_0001, device ID; bit0 must be 1

Ports:
tck_i  input  1  test clock; the only clock
rst_i  input  1  synchronous active-high reset
tms_i  input  1  test mode select
tdi_i  input  1  test data in
tdo_o  output  1  test data out
tdo_oe_o  output  1  TDO output enable; high in SHIFT_DR/SHIFT_IR only
test_logic_reset_o  output  1  high in TEST_LOGIC_RESET
capture_dr_o  output  1  high in CAPTURE_DR
shift_dr_o  output  1  high in SHIFT_DR
pause_dr_o  output  1  high in PAUSE_DR
update_dr_o  output  1  high in UPDATE_DR
extest_select_o  output  1  active instruction is EXTEST
sample_preload_select_o  output  1  active instruction is SAMPLE_PRELOAD
mbist_select_o  output  1  active instruction is MBIST
debug_select_o  output  1  active instruction is DEBUG
bs_chain_tdo_i  input  1  boundary-scan chain serial out
mbist_tdo_i  input  1  MBIST chain serial out
debug_tdo_i  input  1  debug chain serial out

Behaviour:
FSM and reset
- Reset is synchronous: rst_i high at a posedge tck_i forces state=TEST_LOGIC_RESET, the active instruction to RESET_INSTR, and clears the bypass bit.
- rst_i takes priority over tms_i. Asserting it mid-shift aborts the scan without an update strobe.
- States follow standard TAP transitions on tms_i at each posedge: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- TMS=1 for 5 consecutive clocks reaches TLR from any state.
- Strobe outputs are Moore decodes of the state register: no combinational path from tms_i.

Instruction register
- ir_shift is loaded with {IR_LEN-2 zeros, 2'b01} in CAP_IR.
- In SH_IR it shifts right: MSB takes tdi_i, LSB drives TDO.
- ir_active loads from ir_shift in UPD_IR only, so the selects change one cycle after UPD_IR is entered.
- In TLR, ir_active = RESET_INSTR.
- Encodings (IR_LEN=4; wider widths zero-extend, BYPASS is all-ones):
  - EXTEST 0000
  - SAMPLE_PRELOAD 0001
  - IDCODE 0010
  - MBIST 1000
  - DEBUG 1001
  - BYPASS all-ones
  - any other code decodes as BYPASS
- Exactly one select (or none, for BYPASS/IDCODE) is high at any time. All selects are 0 in TLR unless RESET_INSTR selects one.

Data registers
- bypass_q is cleared in CAP_DR and loads tdi_i in SH_DR when BYPASS is active.
- TDI to TDO latency through BYPASS is exactly 1 tck.

TDO
- Combinational mux of the selected source, driven only when tdo_oe_o=1; tdo_o=0 otherwise.
- SH_IR selects ir_shift[0].
- SH_DR selects by instruction: EXTEST/SAMPLE_PRELOAD → bs_chain_tdo_i, MBIST → mbist_tdo_i, DEBUG → debug_tdo_i, IDCODE → idcode_shift[0], BYPASS → bypass_q.
- No negedge retiming happens in this block; pad-level retiming is done at top level.

Optional Feature:
JTAG_TAP_IDCODE_EN
- Defined:
  - A 32-bit idcode_shift register loads IDCODE_VAL in CAP_DR.
  - It shifts right in SH_DR with tdi_i entering at bit 31.
  - RESET_INSTR=IDCODE.
- Undefined:
  - No idcode register is built.
  - The IDCODE code decodes as BYPASS and RESET_INSTR=BYPASS.
  - The first DR-scan bit after TLR is 0.

Decomposition:
- Package jtag_pkg holds:
  - the tap_state_e enum (4-bit)
  - the instruction code constants
  - IR_CAPTURE_PATTERN
  - the default IDCODE_VAL
- One sub-module, jtag_tap_fsm: state register, next-state logic and strobe decodes.
- IR, data registers and TDO mux stay in jtag_tap_ctrl.

Test Plan:
- Reset and TLR entry:
  - rst_i=1 for 1 clk → TLR, test_logic_reset_o=1, all selects 0.
  - From SH_DR with TMS=1 for 5 clks → TLR.
- IR scan: load 0000 via SH_IR → extest_select_o=1 on the cycle after UPD_IR; shifted-out IR bits are 1,0,0,0 (LSB first).
- BYPASS: IR=1111, then shift DR with tdi pattern 1011 → tdo shows 0,1,0,1 (capture 0, then 1-cycle delay).
- IDCODE (JTAG_TAP_IDCODE_EN defined): TLR → RTI → DR scan of 32 bits → tdo stream equals 32'h1180_0001 LSB first. Without the macro, the first bit is 0.
- Chain routing: IR=1001, SH_DR with debug_tdo_i toggling → tdo_o follows it; mbist_tdo_i and bs_chain_tdo_i are ignored.
- Reset mid-operation: rst_i asserted in SH_DR → next state TLR, no update_dr_o pulse, ir_active=RESET_INSTR.
